regfile_multi: RTL and testbench
================================

# regfile_multi

Parametrised multi-port register file for the processor datapath, replacing the fixed 8×16-bit, two-read-port file. It adds a synchronous write port with enable, N combinational read ports, a per-register pending (scoreboard) bit for hazard detection, and a sequenced bulk-clear engine. It sits between decode (read and reserve) and writeback (write).

## Interface
- DATA_W, 16: register width in bits.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W registers.
- N_RD, 2: number of read ports.
- ZERO_R0, 0: if 1, r0 reads as 0, writes to it are discarded, and it can never be pending.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- writeEn  in  1  write strobe.
- writeAddr  in  ADDR_W  write address.
- writeData  in  DATA_W  write data.
- readAddr  in  N_RD*ADDR_W  packed read addresses; port k is bits [k*ADDR_W +: ADDR_W].
- readData  out  N_RD*DATA_W  packed read data, combinational.
- readPend  out  N_RD  pending bit of each addressed register.
- reserveEn  in  1  marks reserveAddr pending (an in-flight producer).
- reserveAddr  in  ADDR_W  register to reserve.
- clearReq  in  1  single-cycle request to zero all registers and pending bits.
- clearBusy  out  1  high while the clear engine runs.

## Operation
- Reset (rst_n=0 at an edge): all registers 0, all pending bits 0, FSM to IDLE, clearBusy 0. Reset during CLEAR aborts the clear; the end state is still all-zero.
- Write: at an edge with writeEn=1 in IDLE, r[writeAddr] <= writeData and pend[writeAddr] <= 0.
- Reserve: at an edge with reserveEn=1 in IDLE, pend[reserveAddr] <= 1.
- Reserve and write to the same address in one cycle: data is written and pend ends at 1. The reserve belongs to a younger instruction.
- Read: readData[k] = r[readAddr[k]] and readPend[k] = pend[readAddr[k]], purely combinational. Any number of ports may address the same register.
- ZERO_R0=1: address 0 reads 0 with pend 0; write/reserve to r0 is a no-op.
- FSM states:
  - IDLE → CLEAR when clearReq=1; the clear counter loads 0.
  - CLEAR: each cycle r[cnt] <= 0 and pend[cnt] <= 0, then cnt++. After cnt = DEPTH-1 is cleared → IDLE.
  - In CLEAR, writeEn, reserveEn and clearReq are ignored (dropped, not queued). Reads stay live and return partially cleared contents.
- The counter is ADDR_W bits wide and wraps naturally. The terminal test is cnt == DEPTH-1, not overflow.

## Timing
- Write latency: 1 edge. Data is visible on readData the same cycle only with bypass enabled (see Configuration); otherwise from the cycle after the edge.
- Pending: set or cleared at the edge; readPend reflects it the following cycle. With bypass enabled, a same-cycle write to the read address forces readPend[k]=0, unless reserveEn targets the same address.
- Clear: clearReq sampled at edge E. clearBusy is high from E through the edge that clears r[DEPTH-1] (exactly DEPTH cycles), and low the cycle after. The first accepted write is at edge E+DEPTH+1.
- clearReq while clearBusy=1 is ignored.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If writeEn=1 (in IDLE) and writeAddr == readAddr[k], readData[k] = writeData in that same cycle.
  - Ignored for r0 when ZERO_R0=1, and during CLEAR.
- REGFILE_BYPASS_EN undefined: reads return stored contents only; the read-after-write penalty is one cycle.

## Structure
- Package regfile_pkg:
  - FSM state enum (RF_IDLE, RF_CLEAR).
  - Default width constants (RF_DATA_W=16, RF_ADDR_W=3, RF_N_RD=2).
- Sub-module regfile_scoreboard:
  - Owns the DEPTH pending bits, reserve/write/clear update priority and ZERO_R0 masking.
  - Exposes a DEPTH-wide pend vector to the parent for read-port muxing.
- Parent holds the data array, the clear FSM/counter and the read muxes.

## Test plan
- Reset then read all 8 addresses on both ports → readData 0x0000, readPend 0.
- Write 0x1234 to r3; next cycle read r3 on port 0 and port 1 → both 0x1234. Same-cycle read → 0x1234 with bypass, old value 0x0000 without.
- Reserve r5 → readPend=1 next cycle. Write r5=0xBEEF → pend 0. Reserve and write r5 in the same cycle → data 0xBEEF, pend stays 1.
- ZERO_R0=1: write 0xFFFF to r0 and reserve r0 → r0 reads 0x0000, pend 0.
- Fill r0..r7 with 0x0011*i, pulse clearReq:
  - clearBusy high exactly 8 cycles.
  - A write during this window is dropped.
  - Afterwards all registers read 0.
- Drive rst_n=0 at clear cycle 3 → next cycle clearBusy 0 and all registers 0. A write the following cycle is accepted.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared types and default sizes for the multi-port register file.
//   rfState_t : clear-engine state (RF_IDLE, RF_CLEAR)
//   RF_*      : default width / port-count constants
package regfile_pkg;

   localparam int RF_DATA_W = 16;
   localparam int RF_ADDR_W = 3;
   localparam int RF_N_RD   = 2;

   typedef enum logic {
      RF_IDLE  = 1'b0,
      RF_CLEAR = 1'b1
   } rfState_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Per-register pending bits used by decode for hazard detection.
//   clk, rst_n   : clock, synchronous active-low reset
//   writeEn/Addr : accepted writeback, clears the pending bit
//   reserveEn/Addr : accepted reservation, sets the pending bit
//   clearEn/Addr : bulk-clear engine step, clears one bit
//   pend         : all DEPTH pending bits, muxed by the parent
// The parent gates writeEn/reserveEn so they only arrive while idle.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W  = RF_ADDR_W,
   parameter int ZERO_R0 = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    writeEn,
   input  logic [ADDR_W-1:0]       writeAddr,
   input  logic                    reserveEn,
   input  logic [ADDR_W-1:0]       reserveAddr,
   input  logic                    clearEn,
   input  logic [ADDR_W-1:0]       clearAddr,
   output logic [(2**ADDR_W)-1:0]  pend
);

   logic [(2**ADDR_W)-1:0] pendNext;

   always_comb begin
      pendNext = pend;
      if (clearEn) begin
         pendNext[clearAddr] = 1'b0;
      end else begin
         if (writeEn)   pendNext[writeAddr]   = 1'b0;
         // Reserve comes from a younger instruction, so it wins over the write.
         if (reserveEn) pendNext[reserveAddr] = 1'b1;
      end
      if (ZERO_R0 != 0) pendNext[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) pend <= '0;
      else        pend <= pendNext;
   end

endmodule

// File: rtl/regfile_multi.sv
// regfile_multi
// Parametrised register file: one synchronous write port, N_RD combinational
// read ports, per-register pending bits and a sequenced bulk-clear engine.
//   clk, rst_n            : clock, synchronous active-low reset
//   writeEn/Addr/Data     : write port
//   readAddr, readData    : packed read ports (port k at [k*W +: W])
//   readPend              : pending bit of each addressed register
//   reserveEn/Addr        : mark a register pending
//   clearReq, clearBusy   : bulk clear request / engine running
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
//
// state    | meaning
// RF_IDLE  | normal operation, writes/reserves/clearReq accepted
// RF_CLEAR | zeroing r[cnt]/pend[cnt] one per cycle, all requests dropped
module regfile_multi
   import regfile_pkg::*;
#(
   parameter int DATA_W  = RF_DATA_W,
   parameter int ADDR_W  = RF_ADDR_W,
   parameter int N_RD    = RF_N_RD,
   parameter int ZERO_R0 = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     writeEn,
   input  logic [ADDR_W-1:0]        writeAddr,
   input  logic [DATA_W-1:0]        writeData,
   input  logic [N_RD*ADDR_W-1:0]   readAddr,
   output logic [N_RD*DATA_W-1:0]   readData,
   output logic [N_RD-1:0]          readPend,
   input  logic                     reserveEn,
   input  logic [ADDR_W-1:0]        reserveAddr,
   input  logic                     clearReq,
   output logic                     clearBusy
);

   localparam int DEPTH = 2**ADDR_W;

   rfState_t            state, stateNext;
   logic [ADDR_W-1:0]   cnt, cntNext;
   logic [DATA_W-1:0]   regs [DEPTH];
   logic [DEPTH-1:0]    pend;
   logic                isIdle;
   logic                wrAccept;
   logic                rsvAccept;

   assign isIdle    = (state == RF_IDLE);
   assign clearBusy = (state == RF_CLEAR);
   assign wrAccept  = writeEn && isIdle && !((ZERO_R0 != 0) && (writeAddr == '0));
   assign rsvAccept = reserveEn && isIdle;

   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      case (state)
         RF_IDLE: begin
            if (clearReq) begin
               stateNext = RF_CLEAR;
               cntNext   = '0;
            end
         end
         RF_CLEAR: begin
            cntNext = cnt + ADDR_W'(1);
            if (cnt == ADDR_W'(DEPTH - 1)) stateNext = RF_IDLE;
         end
         default: stateNext = RF_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RF_IDLE;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (clearBusy) begin
         regs[cnt] <= '0;
      end else if (wrAccept) begin
         regs[writeAddr] <= writeData;
      end
   end

   regfile_scoreboard #(
      .ADDR_W  (ADDR_W),
      .ZERO_R0 (ZERO_R0)
   ) u_scoreboard (
      .clk         (clk),
      .rst_n       (rst_n),
      .writeEn     (wrAccept),
      .writeAddr   (writeAddr),
      .reserveEn   (rsvAccept),
      .reserveAddr (reserveAddr),
      .clearEn     (clearBusy),
      .clearAddr   (cnt),
      .pend        (pend)
   );

   always_comb begin : readMux
      logic [ADDR_W-1:0] rAddr;
      logic [DATA_W-1:0] rData;
      logic              rPend;
      readData = '0;
      readPend = '0;
      rAddr    = '0;
      rData    = '0;
      rPend    = 1'b0;
      for (int k = 0; k < N_RD; k++) begin
         rAddr = readAddr[k*ADDR_W +: ADDR_W];
         rData = regs[rAddr];
         rPend = pend[rAddr];
`ifdef REGFILE_BYPASS_EN
         // Forward the in-flight write; pend shows its post-edge value.
         if (wrAccept && (writeAddr == rAddr)) begin
            rData = writeData;
            rPend = rsvAccept && (reserveAddr == rAddr);
         end
`endif
         if ((ZERO_R0 != 0) && (rAddr == '0)) begin
            rData = '0;
            rPend = 1'b0;
         end
         readData[k*DATA_W +: DATA_W] = rData;
         readPend[k]                  = rPend;
      end
   end

endmodule

// File: tb/tb_regfile_multi.sv
module tb_regfile_multi;

   localparam int DW = 16;
   localparam int AW = 3;
   localparam int NR = 2;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n, writeEn, reserveEn, clearReq;
   logic [AW-1:0]  writeAddr, reserveAddr;
   logic [DW-1:0]  writeData;
   logic [NR*AW-1:0] readAddr;
   logic [NR*DW-1:0] rdData, rdDataZ;
   logic [NR-1:0]  rdPend, rdPendZ;
   logic           busy, busyZ;

   int nCmp = 0;
   int nFail = 0;

   // Reference model: index 0 = plain file, index 1 = ZERO_R0 file.
   logic [DW-1:0] mReg [2][DEPTH];
   bit            mPend[2][DEPTH];
   bit            mBusy;
   int            mClr;

   regfile_multi #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_R0(0)) dut (
      .clk(clk), .rst_n(rst_n), .writeEn(writeEn), .writeAddr(writeAddr),
      .writeData(writeData), .readAddr(readAddr), .readData(rdData),
      .readPend(rdPend), .reserveEn(reserveEn), .reserveAddr(reserveAddr),
      .clearReq(clearReq), .clearBusy(busy));

   regfile_multi #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_R0(1)) dutZ (
      .clk(clk), .rst_n(rst_n), .writeEn(writeEn), .writeAddr(writeAddr),
      .writeData(writeData), .readAddr(readAddr), .readData(rdDataZ),
      .readPend(rdPendZ), .reserveEn(reserveEn), .reserveAddr(reserveAddr),
      .clearReq(clearReq), .clearBusy(busyZ));

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic modelUpdate();
      if (!rst_n) begin
         for (int i = 0; i < 2; i++)
            for (int j = 0; j < DEPTH; j++) begin
               mReg[i][j] = '0;
               mPend[i][j] = 1'b0;
            end
         mBusy = 1'b0;
         mClr = 0;
      end else if (mBusy) begin
         for (int i = 0; i < 2; i++) begin
            mReg[i][mClr] = '0;
            mPend[i][mClr] = 1'b0;
         end
         mClr++;
         if (mClr == DEPTH) mBusy = 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (writeEn && !(i == 1 && writeAddr == 0)) begin
               mReg[i][writeAddr] = writeData;
               mPend[i][writeAddr] = 1'b0;
            end
            if (reserveEn && !(i == 1 && reserveAddr == 0))
               mPend[i][reserveAddr] = 1'b1;
         end
         if (clearReq) begin
            mBusy = 1'b1;
            mClr = 0;
         end
      end
   endtask

   function automatic logic [DW-1:0] expData(int inst, logic [AW-1:0] a);
      logic [DW-1:0] d;
      d = mReg[inst][a];
`ifdef REGFILE_BYPASS_EN
      if (!mBusy && writeEn && writeAddr == a && !(inst == 1 && a == 0)) d = writeData;
`endif
      return d;
   endfunction

   function automatic logic expPend(int inst, logic [AW-1:0] a);
      logic p;
      p = mPend[inst][a];
`ifdef REGFILE_BYPASS_EN
      if (!mBusy && writeEn && writeAddr == a && !(inst == 1 && a == 0))
         p = reserveEn && reserveAddr == a;
`endif
      return p;
   endfunction

   function automatic logic [DW-1:0] gotData(int inst, int k);
      return (inst == 1) ? rdDataZ[k*DW +: DW] : rdData[k*DW +: DW];
   endfunction

   function automatic logic gotPend(int inst, int k);
      return (inst == 1) ? rdPendZ[k] : rdPend[k];
   endfunction

   task automatic step();
      @(posedge clk);
      modelUpdate();
      #1;
   endtask

   task automatic idle();
      rst_n = 1'b1;
      writeEn = 1'b0;
      reserveEn = 1'b0;
      clearReq = 1'b0;
   endtask

   task automatic test_reset();
      logic [AW-1:0] a;
      idle();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      nCmp++;
      if (busy !== 1'b0 || busyZ !== 1'b0) begin
         nFail++;
         $display("FAIL reset_busy: got %b/%b expected 0", busy, busyZ);
      end
      for (int i = 0; i < DEPTH; i++) begin
         a = i[AW-1:0];
         readAddr = {a, a};
         #1;
         for (int inst = 0; inst < 2; inst++)
            for (int k = 0; k < NR; k++) begin
               nCmp++;
               if (gotData(inst, k) !== 16'h0000 || gotPend(inst, k) !== 1'b0) begin
                  nFail++;
                  $display("FAIL reset_read r%0d inst%0d port%0d: got %h/%b expected 0000/0",
                           i, inst, k, gotData(inst, k), gotPend(inst, k));
               end
            end
         step();
      end
   endtask

   task automatic test_write_read();
      logic [DW-1:0] sameExp;
`ifdef REGFILE_BYPASS_EN
      sameExp = 16'h1234;
`else
      sameExp = 16'h0000;
`endif
      idle();
      writeEn = 1'b1; writeAddr = 3'd3; writeData = 16'h1234;
      readAddr = {3'd3, 3'd3};
      #1;
      nCmp++;
      if (rdData[15:0] !== sameExp) begin
         nFail++;
         $display("FAIL same_cycle_read: got %h expected %h", rdData[15:0], sameExp);
      end
      step();
      idle();
      #1;
      for (int k = 0; k < NR; k++) begin
         nCmp++;
         if (rdData[k*DW +: DW] !== 16'h1234) begin
            nFail++;
            $display("FAIL write_read port%0d: got %h expected 1234", k, rdData[k*DW +: DW]);
         end
      end
   endtask

   task automatic test_reserve();
      idle();
      readAddr = {3'd5, 3'd5};
      reserveEn = 1'b1; reserveAddr = 3'd5;
      step();
      idle();
      #1;
      nCmp++;
      if (rdPend !== 2'b11) begin
         nFail++;
         $display("FAIL reserve_pend: got %b expected 11", rdPend);
      end
      writeEn = 1'b1; writeAddr = 3'd5; writeData = 16'hBEEF;
      step();
      idle();
      #1;
      nCmp++;
      if (rdPend[0] !== 1'b0 || rdData[15:0] !== 16'hBEEF) begin
         nFail++;
         $display("FAIL write_clears_pend: got %h/%b expected beef/0", rdData[15:0], rdPend[0]);
      end
      writeEn = 1'b1; writeAddr = 3'd5; writeData = 16'hBEEF;
      reserveEn = 1'b1; reserveAddr = 3'd5;
      step();
      idle();
      #1;
      nCmp++;
      if (rdPend[1] !== 1'b1 || rdData[31:16] !== 16'hBEEF) begin
         nFail++;
         $display("FAIL reserve_and_write: got %h/%b expected beef/1", rdData[31:16], rdPend[1]);
      end
   endtask

   task automatic test_zero_r0();
      idle();
      readAddr = {3'd0, 3'd0};
      writeEn = 1'b1; writeAddr = 3'd0; writeData = 16'hFFFF;
      reserveEn = 1'b1; reserveAddr = 3'd0;
      step();
      idle();
      #1;
      nCmp++;
      if (rdDataZ[15:0] !== 16'h0000 || rdPendZ[0] !== 1'b0) begin
         nFail++;
         $display("FAIL zero_r0: got %h/%b expected 0000/0", rdDataZ[15:0], rdPendZ[0]);
      end
      nCmp++;
      if (rdData[15:0] !== 16'hFFFF || rdPend[0] !== 1'b1) begin
         nFail++;
         $display("FAIL plain_r0: got %h/%b expected ffff/1", rdData[15:0], rdPend[0]);
      end
   endtask

   task automatic test_clear();
      int busyCnt = 0;
      bit seen = 1'b0;
      bit done = 1'b0;
      idle();
      for (int i = 0; i < DEPTH; i++) begin
         writeEn = 1'b1; writeAddr = i[AW-1:0]; writeData = 16'(17 * i);
         step();
      end
      idle();
      clearReq = 1'b1;
      step();
      for (int c = 0; c < 20 && !done; c++) begin
         idle();
         if (busy) begin
            busyCnt++;
            seen = 1'b1;
         end else if (seen) begin
            done = 1'b1;
         end
         if (!done) begin
            if (busyCnt == 5) begin
               readAddr = {3'd4, 3'd3};
               #1;
               nCmp++;
               if (rdData[15:0] !== 16'h0000 || rdData[31:16] !== 16'h0044) begin
                  nFail++;
                  $display("FAIL partial_clear: got r3=%h r4=%h expected 0000/0044",
                           rdData[15:0], rdData[31:16]);
               end
               readAddr = {3'd1, 3'd1};
               #1;
               nCmp++;
               if (rdData[15:0] !== 16'h0000 || rdPend[0] !== 1'b0) begin
                  nFail++;
                  $display("FAIL write_dropped_in_clear: got %h/%b expected 0000/0",
                           rdData[15:0], rdPend[0]);
               end
            end
            if (busyCnt == 4) begin
               writeEn = 1'b1; writeAddr = 3'd1; writeData = 16'h5555;
               reserveEn = 1'b1; reserveAddr = 3'd1;
            end
            if (busyCnt == 6) clearReq = 1'b1;
            step();
         end
      end
      nCmp++;
      if (busyCnt != 8 || !done) begin
         nFail++;
         $display("FAIL clear_busy_len: got %0d cycles (ended=%0b) expected 8", busyCnt, done);
      end
      for (int i = 0; i < DEPTH; i++) begin
         readAddr = {i[AW-1:0], i[AW-1:0]};
         #1;
         nCmp++;
         if (rdData[15:0] !== 16'h0000 || rdPend[0] !== 1'b0) begin
            nFail++;
            $display("FAIL after_clear r%0d: got %h/%b expected 0000/0", i, rdData[15:0], rdPend[0]);
         end
         if (i == DEPTH - 1) begin
            writeEn = 1'b1; writeAddr = 3'd2; writeData = 16'hABCD;
         end
         step();
         idle();
      end
      readAddr = {3'd2, 3'd2};
      #1;
      nCmp++;
      if (rdData[15:0] !== 16'hABCD) begin
         nFail++;
         $display("FAIL write_after_clear: got %h expected abcd", rdData[15:0]);
      end
   endtask

   task automatic test_reset_during_clear();
      idle();
      writeEn = 1'b1; writeAddr = 3'd5; writeData = 16'h5A5A;
      step();
      idle();
      clearReq = 1'b1;
      step();
      idle();
      step();
      step();
      rst_n = 1'b0;
      step();
      idle();
      readAddr = {3'd5, 3'd5};
      #1;
      nCmp++;
      if (busy !== 1'b0 || rdData[15:0] !== 16'h0000) begin
         nFail++;
         $display("FAIL reset_in_clear: got busy=%b r5=%h expected 0/0000", busy, rdData[15:0]);
      end
      writeEn = 1'b1; writeAddr = 3'd4; writeData = 16'h4444;
      step();
      idle();
      readAddr = {3'd4, 3'd4};
      #1;
      nCmp++;
      if (rdData[31:16] !== 16'h4444 || busy !== 1'b0) begin
         nFail++;
         $display("FAIL write_after_reset: got %h busy=%b expected 4444/0", rdData[31:16], busy);
      end
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      for (int n = 0; n < 400; n++) begin
         rst_n       = ($urandom_range(0, 99) != 0);
         writeEn     = ($urandom_range(0, 1) == 1);
         reserveEn   = ($urandom_range(0, 2) == 0);
         clearReq    = ($urandom_range(0, 39) == 0);
         writeAddr   = AW'($urandom_range(0, DEPTH - 1));
         reserveAddr = AW'($urandom_range(0, DEPTH - 1));
         writeData   = DW'($urandom());
         readAddr    = NR*AW'($urandom());
         #1;
         nCmp++;
         if (busy !== mBusy || busyZ !== mBusy) begin
            nFail++;
            $display("FAIL rand_busy cyc%0d: got %b/%b expected %b", n, busy, busyZ, mBusy);
         end
         for (int inst = 0; inst < 2; inst++)
            for (int k = 0; k < NR; k++) begin
               a = readAddr[k*AW +: AW];
               nCmp++;
               if (gotData(inst, k) !== expData(inst, a) || gotPend(inst, k) !== expPend(inst, a)) begin
                  nFail++;
                  $display("FAIL rand_read cyc%0d inst%0d port%0d r%0d: got %h/%b expected %h/%b",
                           n, inst, k, a, gotData(inst, k), gotPend(inst, k),
                           expData(inst, a), expPend(inst, a));
               end
            end
         step();
      end
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      writeEn = 1'b0; reserveEn = 1'b0; clearReq = 1'b0;
      writeAddr = '0; reserveAddr = '0; writeData = '0; readAddr = '0;
      mBusy = 1'b0; mClr = 0;
      test_reset();
      test_write_read();
      test_reserve();
      test_zero_r0();
      test_clear();
      test_reset_during_clear();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
